// File: rtl/dir_rom_arbiter_pkg.sv
// Shared constants and the round-robin step helper for the shared dir-ROM arbiter
// and other shared-ROM stages.
package dir_arb_pkg;

    localparam int DIR_W  = 5;
    localparam int ADDR_W = 8;
    localparam int STAT_W = 16;

    // Next lane index after idx, wrapping modulo n.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/dir_rom_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request after last_id.
// The grant is gated by en, but the winner index is always reported.
module rr_arbiter
    import dir_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] last_id,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] win_id,
    output logic            win_valid
);

    always_comb begin
        int unsigned cur;
        grant     = '0;
        win_id    = '0;
        win_valid = 1'b0;
        cur       = 32'(last_id);
        for (int k = 0; k < NREQ; k++) begin
            cur = rr_next(cur, NREQ);
            if (!win_valid && req[cur[ID_W-1:0]]) begin
                win_valid               = 1'b1;
                win_id                  = cur[ID_W-1:0];
                grant[cur[ID_W-1:0]]    = en;
            end
        end
    end

endmodule

// File: rtl/dir_rom_arbiter.sv
// Round-robin shared dir-ROM arbiter with a 2-stage (address, data) pipeline.
// Optional per-lane grant counters are enabled with DIR_ROM_ARB_STATS_EN.
module dir_rom_arbiter
    import dir_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    output logic [NREQ-1:0]        req_ready,
    output logic [ADDR_W-1:0]      rom_a,
    input  logic [DIR_W-1:0]       rom_spo,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DIR_W-1:0]       out_dir,
    output logic [ID_W-1:0]        out_id
`ifdef DIR_ROM_ARB_STATS_EN
    ,
    input  logic                   stat_clr,
    output logic [NREQ*STAT_W-1:0] stat_grants
`endif
);

    logic              s1_valid;
    logic [ADDR_W-1:0] s1_addr;
    logic [ID_W-1:0]   s1_id;
    logic [ID_W-1:0]   last_id;

    logic              s2_adv;
    logic              s1_adv;
    logic              arb_en;
    logic              win_valid;
    logic [ID_W-1:0]   win_id;
    logic [ADDR_W-1:0] sel_addr;

    // S1 may refill in the same cycle S2 drains, so a full pipe keeps streaming.
    assign s2_adv = !out_valid || out_ready;
    assign s1_adv = !s1_valid || s2_adv;
    assign arb_en = s1_adv && !rst;
    assign rom_a  = s1_addr;

    rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_arb (
        .req       (req_valid),
        .last_id   (last_id),
        .en        (arb_en),
        .grant     (req_ready),
        .win_id    (win_id),
        .win_valid (win_valid)
    );

    always_comb begin
        sel_addr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_id == ID_W'(i)) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_addr   <= '0;
            s1_id     <= '0;
            last_id   <= ID_W'(NREQ - 1);
            out_valid <= 1'b0;
            out_dir   <= '0;
            out_id    <= '0;
        end else begin
            if (s2_adv) begin
                out_valid <= s1_valid;
                out_dir   <= rom_spo;
                out_id    <= s1_id;
            end
            if (s1_adv) begin
                s1_valid <= win_valid;
                if (win_valid) begin
                    s1_addr <= sel_addr;
                    s1_id   <= win_id;
                    last_id <= win_id;
                end
            end
        end
    end

`ifdef DIR_ROM_ARB_STATS_EN
    for (genvar i = 0; i < NREQ; i++) begin : g_stat
        logic [STAT_W-1:0] cnt;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt <= '0;
            end else if (stat_clr) begin
                cnt <= '0;
            end else if (req_valid[i] && req_ready[i] && (cnt != '1)) begin
                cnt <= cnt + STAT_W'(1);
            end
        end

        assign stat_grants[i*STAT_W +: STAT_W] = cnt;
    end
`endif

endmodule
